// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 block packer: FSM states,
// padding bytes and the standard Keccak rates.
package sha3_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam logic [7:0] PAD_END      = 8'h80;
    localparam logic [7:0] SHA3_DOMAIN  = 8'h06;
    localparam logic [7:0] SHAKE_DOMAIN = 8'h1F;

    localparam int RATE_SHA3_224 = 144;
    localparam int RATE_SHA3_256 = 136;
    localparam int RATE_SHA3_384 = 104;
    localparam int RATE_SHA3_512 = 72;

endpackage

// File: rtl/sha3_pad_insert.sv
// Combinational multi-rate padding: XORs the domain byte in at i_idx and
// PAD_END into the final rate byte (both land on one byte when i_idx is last).
module sha3_pad_insert
    import sha3_pkg::*;
#(
    parameter int RATE_BYTES = 136,
    parameter int IDX_W      = 8
) (
    input  logic [RATE_BYTES*8-1:0] i_blk,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [7:0]              i_domain,
    output logic [RATE_BYTES*8-1:0] o_blk
);

    always_comb begin
        o_blk = i_blk;
        for (int k = 0; k < RATE_BYTES; k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_blk[k*8 +: 8] = i_blk[k*8 +: 8] ^ i_domain;
            end
        end
        o_blk[(RATE_BYTES-1)*8 +: 8] = o_blk[(RATE_BYTES-1)*8 +: 8] ^ PAD_END;
    end

endmodule

// File: rtl/sha3_block_packer.sv
// Packs a little-endian word stream into Keccak rate blocks with SHA-3 padding.
// Optional block counter output enabled by SHA3_PACKER_STATS_EN.
module sha3_block_packer
    import sha3_pkg::*;
#(
    parameter int         DATA_WIDTH  = 16,
    parameter int         RATE_BYTES  = 136,
    parameter logic [7:0] DOMAIN_BYTE = SHA3_DOMAIN
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [DATA_WIDTH/8-1:0]   in_keep,
    output logic                      in_ready,
    output logic [RATE_BYTES*8-1:0]   blk_data,
    output logic                      blk_valid,
    output logic                      blk_last,
    input  logic                      blk_ready
`ifdef SHA3_PACKER_STATS_EN
    ,
    output logic [15:0]               blk_count
`endif
);

    localparam int KB = DATA_WIDTH / 8;
    localparam int CW = $clog2(RATE_BYTES + 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_armed;
    logic [CW-1:0]           r_cnt;
    logic [RATE_BYTES*8-1:0] r_blk;
    logic                    r_blk_last;
    logic                    r_pad_pend;

    logic                    w_accept;
    logic [CW-1:0]           w_nbytes;
    logic [CW-1:0]           w_end;
    logic                    w_full;
    logic [RATE_BYTES*8-1:0] w_merged;
    logic [RATE_BYTES*8-1:0] w_padded;
    logic [RATE_BYTES*8-1:0] w_pad_blk;

    assign w_accept = in_valid & in_ready;
    assign w_end    = r_cnt + w_nbytes;
    assign w_full   = (w_end == CW'(RATE_BYTES));

    always_comb begin
        w_nbytes = '0;
        for (int i = 0; i < KB; i++) begin
            if (!in_last || in_keep[i]) begin
                w_nbytes = w_nbytes + CW'(1);
            end
        end
    end

    // Keep is contiguous from lane 0, so lane i always lands at r_cnt + i.
    always_comb begin
        w_merged = r_blk;
        for (int i = 0; i < KB; i++) begin
            if (!in_last || in_keep[i]) begin
                w_merged[(int'(r_cnt) + i)*8 +: 8] = in_data[i*8 +: 8];
            end
        end
    end

    sha3_pad_insert #(.RATE_BYTES(RATE_BYTES), .IDX_W(CW)) u_pad_tail (
        .i_blk    (w_merged),
        .i_idx    (w_end),
        .i_domain (DOMAIN_BYTE),
        .o_blk    (w_padded)
    );

    sha3_pad_insert #(.RATE_BYTES(RATE_BYTES), .IDX_W(CW)) u_pad_only (
        .i_blk    ({RATE_BYTES*8{1'b0}}),
        .i_idx    ({CW{1'b0}}),
        .i_domain (DOMAIN_BYTE),
        .o_blk    (w_pad_blk)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_accept && (in_last || w_full)) w_next = EMIT;
            EMIT:    if (blk_ready) w_next = r_pad_pend ? PAD : FILL;
            PAD:     w_next = EMIT;
            default: w_next = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == FILL) && r_armed;
        blk_valid = (r_state == EMIT);
        blk_last  = r_blk_last;
        blk_data  = r_blk;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_blk      <= '0;
            r_blk_last <= 1'b0;
            r_pad_pend <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (in_last && !w_full) begin
                            r_blk      <= w_padded;
                            r_blk_last <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            // A last word that exactly fills the block defers its padding to PAD.
                            r_blk      <= w_merged;
                            r_blk_last <= 1'b0;
                            r_cnt      <= w_full ? '0 : w_end;
                            r_pad_pend <= in_last;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        r_blk      <= '0;
                        r_cnt      <= '0;
                        r_blk_last <= 1'b0;
                    end
                end
                PAD: begin
                    r_blk      <= w_pad_blk;
                    r_blk_last <= 1'b1;
                    r_pad_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA3_PACKER_STATS_EN
    logic [15:0] r_blk_count;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_blk_count <= '0;
        end else if (blk_valid && blk_ready) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_sha3_block_packer.sv
// Bench for sha3_block_packer: messages are padded and split into blocks by a
// byte-queue reference model and compared block by block at the output.
module tb_sha3_block_packer;

    localparam int DW   = 16;
    localparam int RATE = 136;
    localparam int BW   = RATE * 8;

    typedef logic [7:0] bq_t[$];

    logic          ACLK;
    logic          ARESETn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic [1:0]    in_keep;
    logic          in_ready;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ready;
`ifdef SHA3_PACKER_STATS_EN
    logic [15:0]   blk_count;
`endif

    sha3_block_packer #(.DATA_WIDTH(DW), .RATE_BYTES(RATE), .DOMAIN_BYTE(8'h06)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_keep   (in_keep),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
`ifdef SHA3_PACKER_STATS_EN
        ,
        .blk_count (blk_count)
`endif
    );

    int            total = 0;
    int            bad   = 0;
    int            ready_mode = 0;   // 0 random, 1 always, 2 never
    int            xfer_cnt = 0;
    logic [BW-1:0] exp_data[$];
    logic          exp_last[$];

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
        for (int k = 0; k < RATE; k++) begin
            if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
        end
        return 0;
    endfunction

    // Reference: append 0x06, zero-fill to a whole number of blocks, OR 0x80
    // into the very last byte, then cut into rate-sized blocks.
    task automatic model_push(input bq_t msg);
        bq_t           p;
        int            nblk;
        logic [BW-1:0] d;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % RATE != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / RATE;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < RATE; k++) d[k*8 +: 8] = p[b*RATE + k];
            exp_data.push_back(d);
            exp_last.push_back(b == nblk - 1);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input logic [1:0] keep);
        int   budget;
        logic acc;
        budget = 0;
        acc = 1'b0;
        @(negedge ACLK);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_keep  = keep;
        while (!acc && budget < 2000) begin
            if (in_ready) acc = 1'b1;
            @(posedge ACLK);
            #1;
            budget++;
        end
        if (!acc) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Sends msg as full words plus a last word carrying 0..2 bytes.
    task automatic send_msg(input bq_t msg, input bit model, input bit gaps);
        int          L, nfull, ntail;
        logic [15:0] w;
        L = msg.size();
        ntail = (L % 2 == 1) ? 1 : ((L > 0 && $urandom_range(0, 1) == 1) ? 2 : 0);
        nfull = (L - ntail) / 2;
        if (model) model_push(msg);
        for (int i = 0; i < nfull; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge ACLK);
            send_word({msg[2*i+1], msg[2*i]}, 1'b0, 2'($urandom_range(0, 3)));
        end
        w = 16'($urandom);
        if (ntail >= 1) w[7:0]  = msg[2*nfull];
        if (ntail == 2) w[15:8] = msg[2*nfull+1];
        send_word(w, 1'b1, (ntail == 2) ? 2'b11 : (ntail == 1) ? 2'b01 : 2'b00);
        chk("last_word_latency", {63'd0, blk_valid}, 64'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_data.size() != 0 && budget < 5000) begin
            @(negedge ACLK);
            budget++;
        end
        chk("drain_pending_blocks", 64'(exp_data.size()), 64'd0);
    endtask

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Output side: drives blk_ready, scores transfers, checks backpressure hold.
    initial begin
        logic          hold;
        logic [BW-1:0] held_data;
        logic          held_last;
        logic [BW-1:0] e;
        logic          el;
        int            k;
        hold = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        blk_ready = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                hold = 1'b0;
                blk_ready = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", {63'd0, blk_valid}, 64'd1);
                    k = first_diff(blk_data, held_data);
                    chk($sformatf("hold_data_byte%0d", k), 64'(blk_data[k*8 +: 8]), 64'(held_data[k*8 +: 8]));
                    chk("hold_last", {63'd0, blk_last}, {63'd0, held_last});
                    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
                end
                case (ready_mode)
                    1:       blk_ready = 1'b1;
                    2:       blk_ready = 1'b0;
                    default: blk_ready = ($urandom_range(0, 2) != 0);
                endcase
                if (blk_valid && blk_ready) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected_block", 64'd1, 64'd0);
                    end else begin
                        e  = exp_data.pop_front();
                        el = exp_last.pop_front();
                        k  = first_diff(blk_data, e);
                        chk($sformatf("blk%0d_byte%0d", xfer_cnt, k), 64'(blk_data[k*8 +: 8]), 64'(e[k*8 +: 8]));
                        chk($sformatf("blk%0d_last", xfer_cnt), {63'd0, blk_last}, {63'd0, el});
                    end
                    xfer_cnt++;
                end
                hold = blk_valid && !blk_ready;
                held_data = blk_data;
                held_last = blk_last;
            end
        end
    end

    initial begin
        bq_t q;
        ARESETn  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
        chk("rst_blk_last",  {63'd0, blk_last},  64'd0);
        chk("rst_blk_data_nonzero", {63'd0, |blk_data}, 64'd0);
`ifdef SHA3_PACKER_STATS_EN
        chk("rst_blk_count", 64'(blk_count), 64'd0);
`endif
        ARESETn = 1'b1;
        chk("release_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge ACLK);
        #1;
        chk("release_in_ready_high", {63'd0, in_ready}, 64'd1);

        ready_mode = 1;
        q = {};
        send_msg(q, 1'b1, 1'b0);
        q = {8'h61, 8'h62, 8'h63};
        send_msg(q, 1'b1, 1'b0);
        send_msg(rand_msg(135), 1'b1, 1'b0);
        send_msg(rand_msg(136), 1'b1, 1'b0);
        send_msg(rand_msg(134), 1'b1, 1'b0);
        send_msg(rand_msg(272), 1'b1, 1'b0);
        drain();

        // Backpressure: stall the first "abc" block, offer the next message meanwhile.
        ready_mode = 2;
        q = {8'h61, 8'h62, 8'h63};
        send_msg(q, 1'b1, 1'b0);
        fork
            begin
                repeat (10) @(negedge ACLK);
                ready_mode = 0;
            end
            send_msg(rand_msg(40), 1'b1, 1'b0);
        join
        drain();

        ready_mode = 0;
        for (int m = 0; m < 25; m++) begin
            send_msg(rand_msg($urandom_range(0, 300)), 1'b1, 1'b1);
        end
        drain();

        // Abort a message mid-flight; nothing of it may come out.
        ready_mode = 1;
        for (int i = 0; i < 5; i++) send_word(16'($urandom), 1'b0, 2'b11);
        @(negedge ACLK);
        ARESETn = 1'b0;
        xfer_cnt = 0;
        repeat (3) @(negedge ACLK);
        chk("abort_blk_valid", {63'd0, blk_valid}, 64'd0);
        chk("abort_in_ready",  {63'd0, in_ready},  64'd0);
        ARESETn = 1'b1;
        q = {8'h61, 8'h62, 8'h63};
        send_msg(q, 1'b1, 1'b0);
        drain();
        repeat (3) @(negedge ACLK);
        chk("abort_block_count", 64'(xfer_cnt), 64'd1);
        chk("idle_blk_valid", {63'd0, blk_valid}, 64'd0);
`ifdef SHA3_PACKER_STATS_EN
        chk("stats_blk_count", 64'(blk_count), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
